regfile_wb: RTL and testbench



---
 rtl/regfile_wb_pkg.sv | 12 +
 rtl/regfile_wb_stage.sv | 54 +++++
 rtl/regfile_wb.sv | 72 +++++++
 tb/tb_regfile_wb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared cpu constants for the register file write-back path
package regfile_wb_pkg;

    localparam int         DW         = 32;
    localparam int         AW         = 5;

    localparam logic       WB_SEL_ALU = 1'b0;
    localparam logic       WB_SEL_MEM = 1'b1;

    localparam logic [4:0] REG_ZERO   = 5'd0;

endpackage

// File: rtl/regfile_wb_stage.sv
// rtl/regfile_wb_stage.sv - one-entry write-back staging register with commit and done pulse
module regfile_wb_stage #(
    parameter int DW = regfile_wb_pkg::DW,
    parameter int AW = regfile_wb_pkg::AW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wb_en,
    input  logic          i_wb_sel,
    input  logic [AW-1:0] i_wa,
    input  logic [DW-1:0] i_aluout,
    input  logic [DW-1:0] i_mdr,
    output logic          o_stage_valid,
    output logic [AW-1:0] o_stage_addr,
    output logic [DW-1:0] o_stage_data,
    output logic          o_commit,
    output logic          o_wb_done
);
    import regfile_wb_pkg::*;

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          r_done;
    logic [DW-1:0] w_src;

    assign w_src = (i_wb_sel == WB_SEL_MEM) ? i_mdr : i_aluout;

    // Stage the new request while the previous one commits on the same edge;
    // address/data hold when idle, and wb_done also pulses for r0 writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_valid <= i_wb_en;
            r_done  <= r_valid;
            if (i_wb_en) begin
                r_addr <= i_wa;
                r_data <= w_src;
            end
        end
    end

    // r0 is hardwired to zero, so a staged write to it is dropped at commit
    assign o_commit      = r_valid && (r_addr != AW'(REG_ZERO));
    assign o_stage_valid = r_valid;
    assign o_stage_addr  = r_addr;
    assign o_stage_data  = r_data;
    assign o_wb_done     = r_done;

endmodule

// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - register file with staged write-back and bypassed dual read ports
module regfile_wb #(
    parameter int DW   = regfile_wb_pkg::DW,
    parameter int AW   = regfile_wb_pkg::AW,
    parameter int NREG = 32
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          wb_en,
    input  logic          wb_sel,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] ALUOut,
    input  logic [DW-1:0] MDR,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          wb_pending,
    output logic          wb_done
);
    import regfile_wb_pkg::*;

    logic [DW-1:0] r_regs [NREG];

    logic          w_stage_valid;
    logic [AW-1:0] w_stage_addr;
    logic [DW-1:0] w_stage_data;
    logic          w_commit;

    regfile_wb_stage #(
        .DW (DW),
        .AW (AW)
    ) u_stage (
        .i_clk         (CLK),
        .i_rst_n       (reset),
        .i_wb_en       (wb_en),
        .i_wb_sel      (wb_sel),
        .i_wa          (WA),
        .i_aluout      (ALUOut),
        .i_mdr         (MDR),
        .o_stage_valid (w_stage_valid),
        .o_stage_addr  (w_stage_addr),
        .o_stage_data  (w_stage_data),
        .o_commit      (w_commit),
        .o_wb_done     (wb_done)
    );

    // Architectural array: fully cleared on reset so reads are never X,
    // written only by a committing staged entry (never r0)
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[w_stage_addr] <= w_stage_data;
        end
    end

    // Read ports: r0 is zero, then the staged entry overrides the array so a
    // read never sees data older than the most recent accepted write
    assign RD1 = (RA1 == AW'(REG_ZERO))                     ? '0 :
                 (w_stage_valid && (w_stage_addr == RA1))   ? w_stage_data :
                                                              r_regs[RA1];

    assign RD2 = (RA2 == AW'(REG_ZERO))                     ? '0 :
                 (w_stage_valid && (w_stage_addr == RA2))   ? w_stage_data :
                                                              r_regs[RA2];

    assign wb_pending = w_stage_valid;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - table-driven and scoreboard bench for regfile_wb
module tb_regfile_wb;
    import regfile_wb_pkg::*;

    logic          CLK;
    logic          reset;
    logic          wb_en;
    logic          wb_sel;
    logic [AW-1:0] WA;
    logic [DW-1:0] ALUOut;
    logic [DW-1:0] MDR;
    logic [AW-1:0] RA1;
    logic [AW-1:0] RA2;
    logic [DW-1:0] RD1;
    logic [DW-1:0] RD2;
    logic          wb_pending;
    logic          wb_done;

    regfile_wb #(.DW(DW), .AW(AW), .NREG(32)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .wb_en      (wb_en),
        .wb_sel     (wb_sel),
        .WA         (WA),
        .ALUOut     (ALUOut),
        .MDR        (MDR),
        .RA1        (RA1),
        .RA2        (RA2),
        .RD1        (RD1),
        .RD2        (RD2),
        .wb_pending (wb_pending),
        .wb_done    (wb_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic          en;
        logic          sel;
        logic [AW-1:0] wa;
        logic [DW-1:0] alu;
        logic [DW-1:0] mdr;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e_rd1;
        logic [DW-1:0] e_rd2;
        logic          e_pend;
        logic          e_done;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic          pend;
        logic          done;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[$];

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [DW-1:0] m_regs [32];
    logic          m_sv;
    logic [AW-1:0] m_sa;
    logic [DW-1:0] m_sd;
    logic          m_done;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_sv = 1'b0; m_sa = '0; m_sd = '0; m_done = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] ra);
        if (ra == 0) return '0;
        if (m_sv && m_sa == ra) return m_sd;
        return m_regs[ra];
    endfunction

    task automatic model_step(input logic en, input logic sel, input logic [AW-1:0] wa,
                              input logic [DW-1:0] alu, input logic [DW-1:0] mdr);
        if (m_sv && m_sa != 0) m_regs[m_sa] = m_sd;
        m_done = m_sv;
        m_sv   = en;
        if (en) begin
            m_sa = wa;
            m_sd = sel ? mdr : alu;
        end
    endtask

    // drive one cycle of inputs at the negedge, push expectation, compare after the edge
    task automatic apply(input vec_t v, input bit use_model, input string tag);
        exp_t e;
        exp_t g;
        @(negedge CLK);
        wb_en = v.en; wb_sel = v.sel; WA = v.wa; ALUOut = v.alu; MDR = v.mdr;
        RA1 = v.ra1; RA2 = v.ra2;
        model_step(v.en, v.sel, v.wa, v.alu, v.mdr);
        if (use_model) begin
            e.rd1 = model_read(v.ra1); e.rd2 = model_read(v.ra2);
            e.pend = m_sv; e.done = m_done;
        end else begin
            e.rd1 = v.e_rd1; e.rd2 = v.e_rd2; e.pend = v.e_pend; e.done = v.e_done;
        end
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            g = exp_q.pop_front();
            chk({tag, " RD1"}, RD1, g.rd1);
            chk({tag, " RD2"}, RD2, g.rd2);
            chk({tag, " wb_pending"}, {31'd0, wb_pending}, {31'd0, g.pend});
            chk({tag, " wb_done"}, {31'd0, wb_done}, {31'd0, g.done});
        end
    endtask

    function automatic vec_t mk(input logic en, input logic sel, input logic [AW-1:0] wa,
                                input logic [DW-1:0] alu, input logic [DW-1:0] mdr,
                                input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
                                input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                                input logic p, input logic d);
        vec_t v;
        v.en = en; v.sel = sel; v.wa = wa; v.alu = alu; v.mdr = mdr;
        v.ra1 = ra1; v.ra2 = ra2; v.e_rd1 = r1; v.e_rd2 = r2; v.e_pend = p; v.e_done = d;
        return v;
    endfunction

    initial begin
        vec_t v;

        reset = 1'b0; wb_en = 1'b0; wb_sel = WB_SEL_ALU; WA = '0;
        ALUOut = '0; MDR = '0; RA1 = 5'd5; RA2 = 5'd31;
        model_reset();
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        chk("reset RD1", RD1, 32'h0);
        chk("reset RD2", RD2, 32'h0);
        chk("reset wb_pending", {31'd0, wb_pending}, 32'h0);
        chk("reset wb_done", {31'd0, wb_done}, 32'h0);

        //      en sel wa  alu           mdr           ra1 ra2 rd1           rd2           p  d
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        5,  31, 32'h0,        32'h0,        0, 0));
        vecs.push_back(mk(1, 0, 3,  32'hDEADBEEF, 32'h0,        3,  0,  32'hDEADBEEF, 32'h0,        1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        3,  0,  32'hDEADBEEF, 32'h0,        0, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        3,  0,  32'hDEADBEEF, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 7,  32'h33333333, 32'h11111111, 3,  7,  32'hDEADBEEF, 32'h11111111, 1, 0));
        vecs.push_back(mk(1, 0, 7,  32'h22222222, 32'h44444444, 3,  7,  32'hDEADBEEF, 32'h22222222, 1, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        3,  7,  32'hDEADBEEF, 32'h22222222, 0, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        7,  7,  32'h22222222, 32'h22222222, 0, 0));
        vecs.push_back(mk(1, 0, 0,  32'hFFFFFFFF, 32'h0,        0,  7,  32'h0,        32'h22222222, 1, 0));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        0,  7,  32'h0,        32'h22222222, 0, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        0,  7,  32'h0,        32'h22222222, 0, 0));
        vecs.push_back(mk(1, 0, 1,  32'h1,        32'h0,        1,  2,  32'h1,        32'h0,        1, 0));
        vecs.push_back(mk(1, 0, 2,  32'h2,        32'h0,        1,  2,  32'h1,        32'h2,        1, 1));
        vecs.push_back(mk(1, 0, 2,  32'h0000BEEF, 32'h0,        1,  2,  32'h1,        32'h0000BEEF, 1, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        1,  2,  32'h1,        32'h0000BEEF, 0, 1));
        vecs.push_back(mk(0, 0, 0,  32'h0,        32'h0,        2,  2,  32'h0000BEEF, 32'h0000BEEF, 0, 0));
        vecs.push_back(mk(0, 0, 3,  32'h12345678, 32'h9ABCDEF0, 3,  1,  32'hDEADBEEF, 32'h1,        0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // reset while a write to r9 is staged: it must never reach the array
        v = mk(1, 0, 9, 32'hA5A5A5A5, 32'h0, 9, 3, 32'hA5A5A5A5, 32'hDEADBEEF, 1, 0);
        apply(v, 1'b0, "rst_stage");
        #2;
        wb_en = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_async RD1", RD1, 32'h0);
        chk("rst_async RD2", RD2, 32'h0);
        chk("rst_async wb_pending", {31'd0, wb_pending}, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_rel RD1", RD1, 32'h0);
        chk("rst_rel wb_done", {31'd0, wb_done}, 32'h0);
        chk("rst_rel wb_pending", {31'd0, wb_pending}, 32'h0);
        @(posedge CLK);
        #1;
        chk("rst_rel2 RD1", RD1, 32'h0);
        chk("rst_rel2 wb_done", {31'd0, wb_done}, 32'h0);

        // random traffic on a small address range to stress collisions and bypass
        for (int i = 0; i < 300; i++) begin
            v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                   $urandom, $urandom, AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                   '0, '0, 0, 0);
            apply(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
